// File: rtl/ioctl_rom_loader_if.sv
// SDRAM write port between the ROM loader (master) and the SDRAM controller (slave).
interface ioctl_rom_loader_if #(
  parameter int WADDR_W = 24
);
  logic               o_SDRAM_WR_REQ;
  logic               i_SDRAM_WR_ACK;
  logic [WADDR_W-1:0] o_SDRAM_WR_ADDR;
  logic [15:0]        o_SDRAM_WR_DATA;
  logic [1:0]         o_SDRAM_WR_BE;

  modport master (
    output o_SDRAM_WR_REQ,
    output o_SDRAM_WR_ADDR,
    output o_SDRAM_WR_DATA,
    output o_SDRAM_WR_BE,
    input  i_SDRAM_WR_ACK
  );

  modport slave (
    input  o_SDRAM_WR_REQ,
    input  o_SDRAM_WR_ADDR,
    input  o_SDRAM_WR_DATA,
    input  o_SDRAM_WR_BE,
    output i_SDRAM_WR_ACK
  );
endinterface

// File: rtl/ioctl_rom_loader.sv
// Packs the HPS ioctl byte stream into 16-bit SDRAM words through a small FIFO.
// Optional DIP-switch capture on index 254 when LOADER_DIPSW_EN is defined.
module ioctl_rom_loader #(
  parameter logic [7:0] ROM_INDEX  = 8'd0,
  parameter int         FIFO_DEPTH = 4,
  parameter int         WADDR_W    = 24
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_INITRST,
  input  logic [15:0] ioctl_index,
  input  logic        ioctl_download,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic        ioctl_wait,
  output logic        o_ROM_BUSY,
`ifdef LOADER_DIPSW_EN
  output logic [15:0] o_DIPSW,
`endif
  ioctl_rom_loader_if.master sdram
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [15:0]        data;
    logic [1:0]         be;
  } ent_t;

  state_t state_q, state_d;
  logic   dl_q;
  logic   restart_q, restart_d;
  logic   busy_q, busy_d;
  logic   flush;

  logic               pend_q, pend_d;
  logic [WADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]         pend_data_q, pend_data_d;

  logic          push;
  ent_t          push_ent;
  ent_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;

  logic req_q, req_d;
  ent_t out_q, out_d;
  logic wait_q;

  logic               idx_ok;
  logic               acc;
  logic               rise;
  logic [WADDR_W-1:0] waddr;
  logic               unused_bits;

  assign idx_ok = (ioctl_index[7:0] == ROM_INDEX);
  assign acc    = ioctl_wr & ioctl_download & idx_ok;
  assign rise   = ioctl_download & ~dl_q & idx_ok;
  assign waddr  = ioctl_addr[WADDR_W:1];

  assign unused_bits = ^{ioctl_index[15:8], ioctl_addr[26:WADDR_W+1]};

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      state_q   <= S_IDLE;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
      dl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      restart_q <= restart_d;
      busy_q    <= busy_d;
      dl_q      <= ioctl_download;
    end
  end

  // DRAIN only finishes once nothing is queued, in flight or arriving.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!ioctl_download) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == '0 && !req_q && !push)
          state_d = (restart_q || rise) ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    flush     = (state_q == S_FLUSH);
    busy_d    = (state_d != S_IDLE);
    restart_d = restart_q;
    if (rise && (state_q == S_FLUSH || state_q == S_DRAIN))
      restart_d = 1'b1;
    if (state_d == S_IDLE || state_d == S_LOAD)
      restart_d = 1'b0;
  end

  always_comb begin
    push        = 1'b0;
    push_ent    = {pend_addr_q, 8'h00, pend_data_q, 2'b01};
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    if (acc && !ioctl_addr[0]) begin
      push        = pend_q;
      pend_d      = 1'b1;
      pend_addr_d = waddr;
      pend_data_d = ioctl_data;
    end else if (acc && ioctl_addr[0]) begin
      push   = 1'b1;
      pend_d = 1'b0;
      if (pend_q && pend_addr_q == waddr)
        push_ent = {waddr, ioctl_data, pend_data_q, 2'b11};
      else
        push_ent = {waddr, ioctl_data, 8'h00, 2'b10};
    end else if (flush && pend_q) begin
      push   = 1'b1;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      wait_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q  <= cnt_d;
      wait_q <= (cnt_d >= WAIT_LVL);
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (push) mem_q[wptr_q] <= push_ent;
  end

  // Head is latched when REQ rises and held until the accepting edge.
  always_comb begin
    pop   = req_q & sdram.i_SDRAM_WR_ACK;
    req_d = req_q;
    out_d = out_q;
    if (pop) begin
      req_d = 1'b0;
    end else if (!req_q && cnt_q != '0 && state_q != S_IDLE) begin
      req_d = 1'b1;
      out_d = mem_q[rptr_q];
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      req_q <= 1'b0;
      out_q <= '0;
    end else begin
      req_q <= req_d;
      out_q <= out_d;
    end
  end

  assign ioctl_wait            = wait_q;
  assign o_ROM_BUSY            = busy_q;
  assign sdram.o_SDRAM_WR_REQ  = req_q;
  assign sdram.o_SDRAM_WR_ADDR = out_q.addr;
  assign sdram.o_SDRAM_WR_DATA = out_q.data;
  assign sdram.o_SDRAM_WR_BE   = out_q.be;

`ifdef LOADER_DIPSW_EN
  logic [15:0] dipsw_q;

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST)
      dipsw_q <= 16'hFFFF;
    else if (ioctl_wr && ioctl_download && ioctl_index[7:0] == 8'd254)
      dipsw_q[{ioctl_addr[0], 3'b000} +: 8] <= ioctl_data;
  end

  assign o_DIPSW = dipsw_q;
`endif

endmodule
